// File: rtl/uart_cmd_parser_pkg.sv
// uart_cmd_pkg: opcodes, error codes and parser states shared by the command parser
package uart_cmd_pkg;
  localparam logic [7:0] OP_WR = 8'hA5;
  localparam logic [7:0] OP_RD = 8'h5A;
  localparam logic [1:0] ERR_PARITY = 2'd0;
  localparam logic [1:0] ERR_OPCODE = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, OUT} state_t;
endpackage

// File: rtl/uart_cmd_parser_byte_timer.sv
// uart_byte_timer: inter-byte timeout counter that expires after TIMEOUT_CLKS-1 idle clocks
module uart_byte_timer #(
  parameter int TIMEOUT_CLKS = 200_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CLKS);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clear ? '0 : run ? cnt + 1'b1 : cnt;
  assign expired = run && cnt == CW'(TIMEOUT_CLKS - 1);
endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: parity-checked UART byte stream to SDRAM read/write command decoder
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter bit PARITY_ODD   = 1'b0,
  parameter int TIMEOUT_CLKS = 200_000,
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_parity,
  input  logic              in_en,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_wr,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  output logic              err_en,
  output logic [1:0]        err_code
);
  localparam int AB = ADDR_W / 8;
  localparam int DB = DATA_W / 8;
  localparam int BW = $clog2((AB > DB ? AB : DB) + 1);
  state_t state, state_d, eff;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [DATA_W-1:0] data, data_d;
  logic [BW-1:0] cnt, cnt_d;
  logic wr, wr_d, err_en_d, hs, par_ok, run, expired, last, abort;
  logic [1:0] err_code_d;
  assign hs = state == OUT && cmd_ready;
  assign par_ok = ((^in_data) ^ in_parity) == PARITY_ODD;
  assign run = state == ADDR || state == DATA;
  assign cmd_valid = state == OUT;
  assign cmd_wr = wr;
  assign cmd_addr = addr;
  assign cmd_wdata = data;
  uart_byte_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .run(run),
    .clear(in_en || !run || expired),
    .expired(expired)
  );
  always_comb begin
    eff = hs ? IDLE : state;
    state_d = eff;
    addr_d = hs ? '0 : addr;
    data_d = hs ? '0 : data;
    wr_d = hs ? 1'b0 : wr;
    cnt_d = cnt;
    err_en_d = 1'b0;
    err_code_d = err_code;
    abort = 1'b0;
    last = cnt == (eff == ADDR ? BW'(AB - 1) : BW'(DB - 1));
    if (in_en && eff == OUT) begin
      err_en_d = 1'b1;
      err_code_d = ERR_OVERRUN;
    end else if (in_en && !par_ok) begin
      abort = 1'b1;
      err_en_d = 1'b1;
      err_code_d = ERR_PARITY;
    end else if (in_en && eff == IDLE) begin
      if (in_data == OP_WR || in_data == OP_RD) begin
        state_d = ADDR;
        wr_d = in_data == OP_WR;
      end else begin
        err_en_d = 1'b1;
        err_code_d = ERR_OPCODE;
      end
    end else if (in_en && eff == ADDR) begin
      addr_d = ADDR_W'({addr, in_data});
      cnt_d = last ? '0 : cnt + 1'b1;
      state_d = !last ? ADDR : wr ? DATA : OUT;
    end else if (in_en) begin
      data_d = DATA_W'({data, in_data});
      cnt_d = last ? '0 : cnt + 1'b1;
      state_d = last ? OUT : DATA;
    end else if (expired) begin
      abort = 1'b1;
      err_en_d = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end
    if (abort) begin
      state_d = IDLE;
      addr_d = '0;
      data_d = '0;
      wr_d = 1'b0;
      cnt_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      data <= '0;
      wr <= 1'b0;
      cnt <= '0;
      err_en <= 1'b0;
      err_code <= '0;
    end else begin
      state <= state_d;
      addr <= addr_d;
      data <= data_d;
      wr <= wr_d;
      cnt <= cnt_d;
      err_en <= err_en_d;
      err_code <= err_code_d;
    end
endmodule
